// File: rtl/sonar_pkg.sv
// Shared types and timing helpers for the sonar echo emulator.
// Timing constants are derived from the system clock frequency in Hz.
package sonar_pkg;

    localparam int unsigned CNT_W          = 32;
    localparam int unsigned DIST_W         = 9;
    localparam int unsigned LFSR_W         = 16;
    localparam int unsigned JIT_W          = 4;
    localparam int unsigned FREQ_DEFAULT   = 50_000_000;
    localparam int unsigned MAX_CM_DEFAULT = 400;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_TRIG_HI = 2'd1;
    localparam state_t ST_BURST   = 2'd2;
    localparam state_t ST_ECHO    = 2'd3;

    // Minimum qualifying trigger width (10 us).
    function automatic int unsigned cycles_10_us(input int unsigned f);
        return f / 100_000;
    endfunction

    // Ultrasonic burst duration (200 us).
    function automatic int unsigned burst_cycles(input int unsigned f);
        return f / 5_000;
    endfunction

    // Round-trip time per cm (58 us); 64-bit intermediate avoids overflow.
    function automatic int unsigned cycles_per_cm(input int unsigned f);
        longint unsigned t;
        t = 64'(f) * 64'd58 / 64'd1_000_000;
        return 32'(t);
    endfunction

    // No-object echo width (38 ms).
    function automatic int unsigned timeout_cycles(input int unsigned f);
        longint unsigned t;
        t = 64'(f) * 64'd38 / 64'd1_000;
        return 32'(t);
    endfunction

endpackage

// File: rtl/sonar_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) loaded with seed on reset.
module sonar_lfsr16
    import sonar_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic feedback_c;

    assign feedback_c = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed;
        end else if (enable) begin
            state <= {state[14:0], feedback_c};
        end
    end

endmodule

// File: rtl/sonar_emulator.sv
// HC-SR04 style sonar target emulator: qualifies a trigger, waits out the burst,
// then returns an echo whose width encodes target_cm. Optional SONAR_EMU_JITTER_EN.
module sonar_emulator
    import sonar_pkg::*;
#(
    parameter int unsigned freq   = FREQ_DEFAULT,
    parameter int unsigned MAX_CM = MAX_CM_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] target_cm,
    output logic              echo,
    output logic              busy,
    output logic              short_trig
);

    localparam int unsigned C10_US   = cycles_10_us(freq);
    localparam int unsigned C_BURST  = burst_cycles(freq);
    localparam int unsigned C_PER_CM = cycles_per_cm(freq);
    localparam int unsigned C_TMO    = timeout_cycles(freq);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DIST_W-1:0] latched_cm, latched_cm_n;
    logic              echo_n, short_trig_n, busy_n;
    logic [JIT_W-1:0]  jit_q;
    logic [CNT_W-1:0]  base_width_c, echo_width_c;

`ifdef SONAR_EMU_JITTER_EN
    logic [LFSR_W-1:0] lfsr_state;

    sonar_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .seed   (16'hACE1),
        .state  (lfsr_state)
    );

    // Jitter is captured at the same edge that latches the distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jit_q <= '0;
        end else if (state == ST_TRIG_HI && !trig && cnt >= CNT_W'(C10_US)) begin
            jit_q <= lfsr_state[JIT_W-1:0];
        end
    end
`else
    assign jit_q = '0;
`endif

    // Out-of-range or zero distance means no object: report the timeout width.
    always_comb begin
        if (latched_cm == '0 || CNT_W'(latched_cm) > CNT_W'(MAX_CM)) begin
            base_width_c = CNT_W'(C_TMO);
        end else begin
            base_width_c = CNT_W'(latched_cm) * CNT_W'(C_PER_CM);
        end
        echo_width_c = base_width_c + CNT_W'(jit_q);
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        latched_cm_n = latched_cm;
        echo_n       = echo;
        short_trig_n = 1'b0;
        case (state)
            ST_IDLE: begin
                echo_n = 1'b0;
                if (trig) begin
                    state_n = ST_TRIG_HI;
                    cnt_n   = CNT_W'(1);
                end
            end
            ST_TRIG_HI: begin
                if (trig) begin
                    if (cnt < CNT_W'(C10_US)) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (cnt >= CNT_W'(C10_US)) begin
                    latched_cm_n = target_cm;
                    cnt_n        = CNT_W'(C_BURST);
                    state_n      = ST_BURST;
                end else begin
                    short_trig_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (cnt <= CNT_W'(1)) begin
                    echo_n  = 1'b1;
                    cnt_n   = echo_width_c;
                    state_n = ST_ECHO;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_ECHO: begin
                if (cnt <= CNT_W'(1)) begin
                    echo_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                echo_n  = 1'b0;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            latched_cm <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            latched_cm <= latched_cm_n;
            echo       <= echo_n;
            busy       <= busy_n;
            short_trig <= short_trig_n;
        end
    end

endmodule

// File: doc/sonar_emulator.md
SONAR_EMULATOR -- requirements
Module: sonar_emulator

Interface
REQ-001 Parameter: freq, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter: MAX_CM, default 400, largest target distance that produces an echo.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 trig  input  1  trigger from the sonar initiator; synchronous to clk.
REQ-006 target_cm  input  9  emulated obstacle distance in cm; sampled at qualified trigger end.
REQ-007 echo  output  1  echo pulse back to the initiator.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 short_trig  output  1  one-cycle pulse when a trigger is rejected for being too short.

Function
REQ-010 Constants, integer-derived from freq: CYCLES_10_US = freq/100_000; BURST_CYCLES = freq/5_000 (200 us); CYCLES_PER_CM = freq*58/1_000_000; TIMEOUT_CYCLES = freq*38/1_000.
REQ-011 FSM states: IDLE, TRIG_HI, BURST, ECHO.
REQ-012 IDLE: trig=1 -> TRIG_HI with the width counter set to 1; otherwise remain in IDLE.
REQ-013 TRIG_HI: while trig=1, the width counter increments and saturates at CYCLES_10_US.
REQ-014 TRIG_HI, trig=0 with counter >= CYCLES_10_US: latch target_cm, load the counter with BURST_CYCLES, go to BURST.
REQ-015 TRIG_HI, trig=0 with counter < CYCLES_10_US: pulse short_trig for one cycle, return to IDLE, drive no echo.
REQ-016 BURST: decrement the counter; echo rises on the clock edge exactly BURST_CYCLES cycles after the first cycle trig was sampled low.
REQ-017 ECHO: echo stays high for exactly latched_cm*CYCLES_PER_CM cycles, then falls; the FSM enters IDLE on the same edge.
REQ-018 If the latched value is 0 or greater than MAX_CM, the echo width is TIMEOUT_CYCLES (no-object case).
REQ-019 Arithmetic: 32-bit unsigned counter; product computed at 32 bits; no overflow for freq <= 200 MHz.
REQ-020 trig activity in BURST or ECHO is ignored; it has no effect on timing and does not assert short_trig.
REQ-021 A trig that is still high when the FSM returns to IDLE starts a new TRIG_HI on the next cycle; its width is counted from that cycle.
REQ-022 target_cm changes after the latch point do not affect the current echo.
REQ-023 echo and short_trig are registered outputs; busy decodes the state register.

Reset
REQ-024 rst_n low asynchronously forces: state=IDLE, echo=0, busy=0, short_trig=0, counter=0, latched distance=0.
REQ-025 Reset asserted mid-TRIG_HI, BURST or ECHO aborts the operation immediately; no echo is produced after release until a fresh qualified trigger.

Configuration
REQ-026 Macro SONAR_EMU_JITTER_EN: when defined, a 16-bit LFSR (seed 16'hACE1, advancing every clock) adds its low 4 bits, sampled at the latch point, to the echo width (+0..15 cycles).
REQ-027 Without SONAR_EMU_JITTER_EN, no LFSR is instantiated and echo widths are exact per REQ-017 and REQ-018.

Structure
REQ-028 Shared package sonar_pkg: state encoding typedef, the 10 us, 200 us, 58 us/cm and 38 ms timing constants (as functions of freq), and MAX_CM default.
REQ-029 One sub-module: sonar_lfsr16 (enable, seed, 16-bit state output), instantiated only under SONAR_EMU_JITTER_EN.

Verification (freq=50_000_000: CYCLES_10_US=500, BURST=10_000, CYCLES_PER_CM=2_900, TIMEOUT=1_900_000)
REQ-030 Trigger of 500 cycles, target_cm=100 -> echo rises 10_000 cycles after trig falls; width exactly 290_000 cycles; busy high throughout; short_trig never asserted.
REQ-031 Trigger of 499 cycles -> short_trig single-cycle pulse, echo stays 0, busy low 1 cycle later.
REQ-032 target_cm=0 and, separately, target_cm=401 -> echo width 1_900_000 cycles.
REQ-033 Second trig pulse of 600 cycles during ECHO, and target_cm changed to 5 mid-echo -> first echo width unchanged at 290_000; no second echo.
REQ-034 rst_n pulled low 1_000 cycles into ECHO -> echo=0 and busy=0 without waiting for a clock edge; after release, a 500-cycle trigger with target_cm=1 -> echo width 2_900 cycles.
REQ-035 With SONAR_EMU_JITTER_EN, 32 triggers at target_cm=10 -> every width in [29_000, 29_015], at least two distinct widths, sequence reproducible run-to-run.
